// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: two-entry instruction queue between fetch (IF) and decode (ID).
// The queue holds the head instruction while the hazard unit stalls.
// It drops all wrong-path instructions on a decode-resolved redirect (flush).
// When nothing valid is queued, it presents a NOP to decode.
// Optional feature: define FDB_PERF_EN to build the stall/bubble performance counters;
// otherwise both counter ports are tied to zero.
`default_nettype none

module fetch_decode_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_IF,
  input  logic [15:0] pc2_IF,
  input  logic        valid_IF,
  output logic        fetch_ready,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_ID,
  output logic [15:0] pc2_ID,
  output logic        valid_ID,
  output logic [4:0]  OpCode_ID,
  output logic [2:0]  Rs_ID,
  output logic [2:0]  Rt_ID,
  output logic        overflow_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] bubble_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   instr_mem [DEPTH];
  logic [15:0]   pc2_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Ready and valid are decoded from the occupancy only, so stall/flush never reach fetch_ready.
  assign fetch_ready = (count != CW'(DEPTH));
  assign valid_ID    = (count != '0);
  assign push        = valid_IF & fetch_ready & ~flush;
  assign pop         = valid_ID & ~stall & ~flush;

  assign instr_ID  = valid_ID ? instr_mem[rd_ptr] : NOP_INSTR;
  assign pc2_ID    = valid_ID ? pc2_mem[rd_ptr]   : 16'h0000;
  assign OpCode_ID = instr_ID[15:11];
  assign Rs_ID     = instr_ID[10:8];
  assign Rt_ID     = instr_ID[7:5];

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= instr_IF;
      pc2_mem[wr_ptr]   <= pc2_IF;
    end
  end

  // Pointers and occupancy; a redirect empties the queue and overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Sticky error flag for a fetch that ignored fetch_ready; dropped fetches during a flush are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (valid_IF && !fetch_ready && !flush) begin
      overflow_err <= 1'b1;
    end
  end

`ifdef FDB_PERF_EN
  // Saturating counters of cycles lost to hazard stalls and to an empty queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= 16'h0000;
      bubble_cycles <= 16'h0000;
    end else begin
      if (stall && valid_ID && !flush && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'h0001;
      if (!valid_ID && !flush && bubble_cycles != 16'hFFFF)
        bubble_cycles <= bubble_cycles + 16'h0001;
    end
  end
`else
  assign stall_cycles  = 16'h0000;
  assign bubble_cycles = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: directed-vector self-checking bench for fetch_decode_buffer.
// Builds with or without FDB_PERF_EN; the counter checks follow the build.
module tb_fetch_decode_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_IF;
  logic [15:0] pc2_IF;
  logic        valid_IF;
  logic        fetch_ready;
  logic        stall;
  logic        flush;
  logic [15:0] instr_ID;
  logic [15:0] pc2_ID;
  logic        valid_ID;
  logic [4:0]  OpCode_ID;
  logic [2:0]  Rs_ID;
  logic [2:0]  Rt_ID;
  logic        overflow_err;
  logic [15:0] stall_cycles;
  logic [15:0] bubble_cycles;

  int compare_count = 0;
  int mismatch_count = 0;

  fetch_decode_buffer #(.DEPTH(2), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_IF(instr_IF), .pc2_IF(pc2_IF), .valid_IF(valid_IF),
    .fetch_ready(fetch_ready), .stall(stall), .flush(flush),
    .instr_ID(instr_ID), .pc2_ID(pc2_ID), .valid_ID(valid_ID),
    .OpCode_ID(OpCode_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .overflow_err(overflow_err),
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );

  // Free-running clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compare_count++;
    if (got !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                               input logic st, input logic fl);
    valid_IF = v;
    instr_IF = ins;
    pc2_IF   = pc;
    stall    = st;
    flush    = fl;
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #12;
    checkOutput("rst valid_ID",    {15'd0, valid_ID},     16'h0000);
    checkOutput("rst instr_ID",    instr_ID,              16'h0800);
    checkOutput("rst pc2_ID",      pc2_ID,                16'h0000);
    checkOutput("rst fetch_ready", {15'd0, fetch_ready},  16'h0001);
    checkOutput("rst overflow",    {15'd0, overflow_err}, 16'h0000);
    checkOutput("rst opcode",      {11'd0, OpCode_ID},    16'h0001);
    #1 rst_n = 1'b1;

    // Back-to-back flow: each push visible one cycle later
    applyStimulus(1'b1, 16'hC001, 16'h0002, 1'b0, 1'b0);
    #1;
    checkOutput("pre-push valid", {15'd0, valid_ID}, 16'h0000);
    checkOutput("pre-push instr", instr_ID,          16'h0800);
    tick();
    checkOutput("flow C001 instr", instr_ID,         16'hC001);
    checkOutput("flow C001 pc2",   pc2_ID,           16'h0002);
    checkOutput("flow C001 valid", {15'd0, valid_ID}, 16'h0001);
    applyStimulus(1'b1, 16'hC102, 16'h0004, 1'b0, 1'b0);
    tick();
    checkOutput("flow C102 instr", instr_ID,         16'hC102);
    checkOutput("flow C102 opcode", {11'd0, OpCode_ID}, 16'h0018);
    checkOutput("flow C102 rs",    {13'd0, Rs_ID},   16'h0001);
    checkOutput("flow ready",      {15'd0, fetch_ready}, 16'h0001);
    applyStimulus(1'b1, 16'hC203, 16'h0006, 1'b0, 1'b0);
    tick();
    checkOutput("flow C203 instr", instr_ID,         16'hC203);
    checkOutput("flow C203 pc2",   pc2_ID,           16'h0006);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("flow drain valid", {15'd0, valid_ID}, 16'h0000);
    checkOutput("flow drain instr", instr_ID,          16'h0800);

    // Stall holds the head; queue fills then refuses fetch
    applyStimulus(1'b1, 16'hD928, 16'h0100, 1'b0, 1'b0);
    tick();
    checkOutput("stall head0", instr_ID, 16'hD928);
    applyStimulus(1'b1, 16'hDA48, 16'h0102, 1'b1, 1'b0);
    tick();
    checkOutput("stall head1",  instr_ID, 16'hD928);
    checkOutput("stall full ready", {15'd0, fetch_ready}, 16'h0000);
    checkOutput("stall opcode", {11'd0, OpCode_ID}, 16'h001B);
    checkOutput("stall rt",     {13'd0, Rt_ID},     16'h0001);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall hold %0d", i), instr_ID, 16'hD928);
      checkOutput($sformatf("stall ready %0d", i), {15'd0, fetch_ready}, 16'h0000);
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("release DA48", instr_ID, 16'hDA48);
    checkOutput("release ready", {15'd0, fetch_ready}, 16'h0001);
    applyStimulus(1'b1, 16'hDB68, 16'h0104, 1'b0, 1'b0);
    tick();
    checkOutput("release DB68", instr_ID, 16'hDB68);
    checkOutput("release pc2",  pc2_ID,   16'h0104);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("release empty", {15'd0, valid_ID},     16'h0000);
    checkOutput("release no ovf", {15'd0, overflow_err}, 16'h0000);
`ifndef FDB_PERF_EN
    checkOutput("noperf stall_cycles",  stall_cycles,  16'h0000);
    checkOutput("noperf bubble_cycles", bubble_cycles, 16'h0000);
`endif

    // Flush with a full queue and a fetch in the same cycle
    applyStimulus(1'b1, 16'hE001, 16'h0200, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hE002, 16'h0202, 1'b1, 1'b0);
    tick();
    checkOutput("flush prefill valid", {15'd0, valid_ID},    16'h0001);
    checkOutput("flush prefill ready", {15'd0, fetch_ready}, 16'h0000);
    applyStimulus(1'b1, 16'hE003, 16'h0204, 1'b1, 1'b1);
    tick();
    checkOutput("flush valid",  {15'd0, valid_ID},     16'h0000);
    checkOutput("flush instr",  instr_ID,              16'h0800);
    checkOutput("flush pc2",    pc2_ID,                16'h0000);
    checkOutput("flush ready",  {15'd0, fetch_ready},  16'h0001);
    checkOutput("flush no ovf", {15'd0, overflow_err}, 16'h0000);
    applyStimulus(1'b1, 16'hF001, 16'h0300, 1'b0, 1'b0);
    #1;
    checkOutput("flush drop E003", instr_ID, 16'h0800);
    tick();
    checkOutput("redirect F001", instr_ID, 16'hF001);
    checkOutput("redirect pc2",  pc2_ID,   16'h0300);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("redirect empty", {15'd0, valid_ID}, 16'h0000);

    // Overflow is sticky through flushes
    applyStimulus(1'b1, 16'hE101, 16'h0400, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hE102, 16'h0402, 1'b1, 1'b0);
    tick();
    checkOutput("ovf before", {15'd0, overflow_err}, 16'h0000);
    applyStimulus(1'b1, 16'hE103, 16'h0404, 1'b1, 1'b0);
    tick();
    checkOutput("ovf set",  {15'd0, overflow_err}, 16'h0001);
    checkOutput("ovf head", instr_ID,              16'hE101);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    checkOutput("ovf after flush", {15'd0, overflow_err}, 16'h0001);
    checkOutput("ovf flush valid", {15'd0, valid_ID},     16'h0000);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("ovf idle", {15'd0, overflow_err}, 16'h0001);

    // Asynchronous reset mid-cycle with two entries queued
    applyStimulus(1'b1, 16'hE201, 16'h0500, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hE202, 16'h0502, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("arst pre valid", {15'd0, valid_ID}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst valid", {15'd0, valid_ID},     16'h0000);
    checkOutput("arst ready", {15'd0, fetch_ready},  16'h0001);
    checkOutput("arst ovf",   {15'd0, overflow_err}, 16'h0000);
    checkOutput("arst instr", instr_ID,              16'h0800);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("arst resume", {15'd0, valid_ID}, 16'h0000);

`ifdef FDB_PERF_EN
    // Fresh reset so the counters start from zero
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    checkOutput("perf rst stall",  stall_cycles,  16'h0000);
    checkOutput("perf rst bubble", bubble_cycles, 16'h0000);
    applyStimulus(1'b1, 16'hAA01, 16'h0600, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    repeat (5) tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("perf stall_cycles",  stall_cycles,  16'd5);
    checkOutput("perf bubble_cycles", bubble_cycles, 16'd3);
    repeat (70000) tick();
    checkOutput("perf bubble sat", bubble_cycles, 16'hFFFF);
    checkOutput("perf stall hold", stall_cycles,  16'd5);
`else
    repeat (4) tick();
    checkOutput("noperf end stall",  stall_cycles,  16'h0000);
    checkOutput("noperf end bubble", bubble_cycles, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
